// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: instruction constants and fetch FSM states.
package mips_pkg;

   localparam int unsigned INSTR_W   = 32;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam int unsigned PC_INCR   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_seq.sv
// PC/nPC sequencer: owns the delay-slot PC pair and the pending-branch target,
// and steps both on every advance.
module fetch_pc_seq
   import mips_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              advance,
   input  logic              Branch_taken,
   input  logic [ADDR_W-1:0] Branch_target,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] npc_q, npc_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

   always_comb begin
      pc_d       = pc_q;
      npc_d      = npc_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      if (advance) begin
         // Old nPC is the delay slot; the redirect lands on the following fetch.
         pc_d   = npc_q;
         pend_d = 1'b0;
         if (Branch_taken) begin
            npc_d = Branch_target;
         end else if (pend_q) begin
            npc_d = pend_tgt_q;
         end else begin
            npc_d = npc_q + ADDR_W'(PC_INCR);
         end
      end else if (Branch_taken) begin
         pend_d     = 1'b1;
         pend_tgt_d = Branch_target;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q       <= RESET_PC;
         npc_q      <= RESET_PC + ADDR_W'(PC_INCR);
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         npc_q      <= npc_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register over a req/ack memory handshake.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Stall,
   input  logic               Branch_taken,
   input  logic [ADDR_W-1:0]  Branch_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        Fetch_count,
   output logic [31:0]        Stall_count,
`endif
   output logic [INSTR_W-1:0] IF_Instr,
   output logic [ADDR_W-1:0]  IF_PC,
   output logic               IF_LE
);

   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] hold_instr_q;
   logic [ADDR_W-1:0]  hold_pc_q;
   logic               hold_we;
   logic               advance;
   logic [ADDR_W-1:0]  pc;

   fetch_pc_seq #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_seq (
      .Clk           (Clk),
      .Reset         (Reset),
      .advance       (advance),
      .Branch_taken  (Branch_taken),
      .Branch_target (Branch_target),
      .pc            (pc)
   );

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      advance  = 1'b0;
      hold_we  = 1'b0;
      IF_Instr = NOP_INSTR;
      IF_PC    = '0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (!Stall) begin
                  advance  = 1'b1;
                  IF_Instr = imem_rdata;
                  IF_PC    = pc;
               end else begin
                  // Park the word so the request completes and is never reissued.
                  hold_we = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            IF_Instr = hold_instr_q;
            IF_PC    = hold_pc_q;
            if (!Stall) begin
               advance = 1'b1;
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign IF_LE     = advance;
   assign imem_addr = pc;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else begin
         state_q <= state_d;
         if (hold_we) begin
            hold_instr_q <= imem_rdata;
            hold_pc_q    <= pc;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (advance) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (Stall && (state_q == REQ || state_q == HOLD)) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign Fetch_count = fetch_cnt_q;
   assign Stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: one vector per clock cycle, plus a mid-handshake reset.
module tb_fetch_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Stall;
   logic        Branch_taken;
   logic [31:0] Branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] IF_Instr;
   logic [31:0] IF_PC;
   logic        IF_LE;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] Fetch_count;
   logic [31:0] Stall_count;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 Clk = ~Clk;

   fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Stall         (Stall),
      .Branch_taken  (Branch_taken),
      .Branch_target (Branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
`ifdef FETCH_PERF_CNT_EN
      .Fetch_count   (Fetch_count),
      .Stall_count   (Stall_count),
`endif
      .IF_Instr      (IF_Instr),
      .IF_PC         (IF_PC),
      .IF_LE         (IF_LE)
   );

   typedef struct {
      logic        stall;
      logic        ack;
      logic [31:0] rdata;
      logic        br;
      logic [31:0] tgt;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_le;
      logic        chk_data;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(logic st, logic ak, logic [31:0] rd, logic br, logic [31:0] tg,
                               logic rq, logic [31:0] ad, logic le, logic cd,
                               logic [31:0] ins, logic [31:0] pc);
      vec_t v;
      v.stall = st; v.ack = ak; v.rdata = rd; v.br = br; v.tgt = tg;
      v.exp_req = rq; v.exp_addr = ad; v.exp_le = le; v.chk_data = cd;
      v.exp_instr = ins; v.exp_pc = pc;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic st, logic ak, logic [31:0] rd, logic br, logic [31:0] tg);
      Stall = st; imem_ack = ak; imem_rdata = rd; Branch_taken = br; Branch_target = tg;
   endtask

   initial begin
      int le_total;
      int st_total;
      //          stall ack rdata          br tgt            req addr           le chk instr          pc
      vecs[0]  = mk(0, 1, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0000_0000, 0, 0, 32'h0,         32'h0);
      vecs[1]  = mk(0, 1, 32'hA000_0000, 0, 32'h0,         1, 32'h0000_0000, 1, 1, 32'hA000_0000, 32'h0);
      vecs[2]  = mk(0, 1, 32'hA000_0004, 0, 32'h0,         1, 32'h0000_0004, 1, 1, 32'hA000_0004, 32'h4);
      vecs[3]  = mk(0, 1, 32'hA000_0008, 0, 32'h0,         1, 32'h0000_0008, 1, 1, 32'hA000_0008, 32'h8);
      vecs[4]  = mk(0, 1, 32'hA000_000C, 0, 32'h0,         1, 32'h0000_000C, 1, 1, 32'hA000_000C, 32'hC);
      vecs[5]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010, 0, 0, 32'h0,         32'h0);
      vecs[6]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010, 0, 0, 32'h0,         32'h0);
      vecs[7]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010, 0, 0, 32'h0,         32'h0);
      vecs[8]  = mk(0, 1, 32'hA000_0010, 0, 32'h0,         1, 32'h0000_0010, 1, 1, 32'hA000_0010, 32'h10);
      vecs[9]  = mk(0, 1, 32'hA000_0014, 1, 32'h100,       1, 32'h0000_0014, 1, 1, 32'hA000_0014, 32'h14);
      vecs[10] = mk(0, 1, 32'hA000_0018, 0, 32'h0,         1, 32'h0000_0018, 1, 1, 32'hA000_0018, 32'h18);
      vecs[11] = mk(0, 1, 32'hA000_0100, 0, 32'h0,         1, 32'h0000_0100, 1, 1, 32'hA000_0100, 32'h100);
      vecs[12] = mk(1, 1, 32'h2402_0005, 1, 32'h200,       1, 32'h0000_0104, 0, 0, 32'h0,         32'h0);
      vecs[13] = mk(1, 0, 32'h0,         1, 32'h300,       0, 32'h0000_0104, 0, 1, 32'h2402_0005, 32'h104);
      vecs[14] = mk(1, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0104, 0, 1, 32'h2402_0005, 32'h104);
      vecs[15] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0104, 1, 1, 32'h2402_0005, 32'h104);
      vecs[16] = mk(0, 1, 32'hA000_0108, 0, 32'h0,         1, 32'h0000_0108, 1, 1, 32'hA000_0108, 32'h108);
      vecs[17] = mk(0, 1, 32'hA000_0300, 0, 32'h0,         1, 32'h0000_0300, 1, 1, 32'hA000_0300, 32'h300);
      vecs[18] = mk(0, 0, 32'h0,         1, 32'h500,       1, 32'h0000_0304, 0, 0, 32'h0,         32'h0);
      vecs[19] = mk(0, 1, 32'hA000_0304, 1, 32'h600,       1, 32'h0000_0304, 1, 1, 32'hA000_0304, 32'h304);
      vecs[20] = mk(0, 1, 32'hA000_0308, 0, 32'h0,         1, 32'h0000_0308, 1, 1, 32'hA000_0308, 32'h308);
      vecs[21] = mk(0, 1, 32'hA000_0600, 0, 32'h0,         1, 32'h0000_0600, 1, 1, 32'hA000_0600, 32'h600);
      vecs[22] = mk(0, 1, 32'hA000_0604, 1, 32'hFFFF_FFF8, 1, 32'h0000_0604, 1, 1, 32'hA000_0604, 32'h604);
      vecs[23] = mk(0, 1, 32'hA000_0608, 0, 32'h0,         1, 32'h0000_0608, 1, 1, 32'hA000_0608, 32'h608);
      vecs[24] = mk(0, 1, 32'h1234_5678, 0, 32'h0,         1, 32'hFFFF_FFF8, 1, 1, 32'h1234_5678, 32'hFFFF_FFF8);
      vecs[25] = mk(0, 1, 32'h8765_4321, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 1, 32'h8765_4321, 32'hFFFF_FFFC);
      vecs[26] = mk(0, 1, 32'h0BAD_F00D, 0, 32'h0,         1, 32'h0000_0000, 1, 1, 32'h0BAD_F00D, 32'h0);
      vecs[27] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0004, 0, 0, 32'h0,         32'h0);

      // Reset values
      Reset = 1'b0;
      drive(0, 0, 32'h0, 0, 32'h0);
      #3;
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_le", {31'b0, IF_LE}, 32'h0);
      check("rst_instr", IF_Instr, 32'h0);
      check("rst_pc", IF_PC, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_fcnt", Fetch_count, 32'h0);
      check("rst_scnt", Stall_count, 32'h0);
`endif
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;

      le_total = 0;
      st_total = 0;
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].stall, vecs[i].ack, vecs[i].rdata, vecs[i].br, vecs[i].tgt);
         #2;
         check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
         check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
         check($sformatf("v%0d_le", i), {31'b0, IF_LE}, {31'b0, vecs[i].exp_le});
         if (vecs[i].chk_data) begin
            check($sformatf("v%0d_instr", i), IF_Instr, vecs[i].exp_instr);
            check($sformatf("v%0d_pc", i), IF_PC, vecs[i].exp_pc);
         end
         if (vecs[i].exp_le) le_total++;
         if (vecs[i].stall) st_total++;
         @(negedge Clk);
      end

`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", Fetch_count, 32'(le_total));
      check("stall_count", Stall_count, 32'(st_total));
`endif

      // Reset mid-handshake: request outstanding at 0x4, late ack arrives with reset.
      drive(0, 0, 32'h0, 0, 32'h0);
      #2;
      check("mid_req_before", {31'b0, imem_req}, 32'h1);
      @(negedge Clk);
      drive(0, 1, 32'h5555_AAAA, 0, 32'h0);
      Reset = 1'b0;
      #1;
      check("mid_rst_req", {31'b0, imem_req}, 32'h0);
      check("mid_rst_addr", imem_addr, 32'h0);
      check("mid_rst_le", {31'b0, IF_LE}, 32'h0);
      check("mid_rst_instr", IF_Instr, 32'h0);
      check("mid_rst_pc", IF_PC, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("mid_rst_fcnt", Fetch_count, 32'h0);
      check("mid_rst_scnt", Stall_count, 32'h0);
`endif
      @(negedge Clk);
      Reset = 1'b1;
      #2;
      check("restart_idle_req", {31'b0, imem_req}, 32'h0);
      check("restart_idle_le", {31'b0, IF_LE}, 32'h0);
      @(negedge Clk);
      drive(0, 1, 32'hC000_0000, 0, 32'h0);
      #2;
      check("restart_req", {31'b0, imem_req}, 32'h1);
      check("restart_addr", imem_addr, 32'h0);
      check("restart_le", {31'b0, IF_LE}, 32'h1);
      check("restart_pc", IF_PC, 32'h0);
      check("restart_instr", IF_Instr, 32'hC000_0000);
      @(negedge Clk);
      #2;
      check("restart_next_addr", imem_addr, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
